reset_sequencer: RTL and testbench

- Produces the reset inputs for asynchronously-reset registers across the design.
- Assertion of `rst_out` is asynchronous and immediate.
- Deassertion is synchronized to `clk`, stretched for a fixed hold time, then released one domain at a time in a fixed order.
- Also provides a synchronous software-reset request/acknowledge handshake that re-runs the stretch and release sequence without toggling the external reset.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_sync_chain.sv | 19 +
 rtl/reset_sequencer.sv | 111 +++++++++++
 tb/tb_reset_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and width helpers for the reset sequencer
package reset_seq_pkg;

   typedef enum logic [1:0] {ASSERT, STRETCH, RELEASE, RUN} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int cnt_width(input int s, input int g);
      return clog2((s > g ? s : g) + 1);
   endfunction

   function automatic int dom_width(input int n);
      return clog2(n + 1);
   endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// reset_sync_chain: async-set flop chain that synchronizes reset deassertion to clk
module reset_sync_chain #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk,
   input  logic rst,
   output logic rst_sync
);

   logic [SYNC_STAGES-1:0] r_sync;

   // set immediately on rst, shift zeros in once rst is gone
   always_ff @(posedge clk or posedge rst)
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};

   assign rst_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: async-assert reset with synchronized, stretched, in-order domain release and software reset handshake
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 3,
   parameter int STRETCH_CYCLES = 16,
   parameter int NUM_DOMAINS    = 2,
   parameter int DOMAIN_GAP     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sw_rst_req,
   output logic                   sw_rst_ack,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   rst_done
);

   localparam int CNT_W = cnt_width(STRETCH_CYCLES, DOMAIN_GAP);
   localparam int DOM_W = dom_width(NUM_DOMAINS);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(DOMAIN_GAP - 1);
   localparam logic [DOM_W-1:0] DOM_END      = DOM_W'(NUM_DOMAINS);

   state_t                 r_state, w_state;
   logic [CNT_W-1:0]       r_cnt, w_cnt;
   logic [DOM_W-1:0]       r_dom, w_dom;
   logic [NUM_DOMAINS-1:0] r_rst_out, w_rst_out;
   logic                   r_done, w_done;
   logic                   r_ack, w_ack;
   logic                   r_sw_flag, w_sw_flag;
   logic                   w_rst_sync;

   reset_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .rst_sync (w_rst_sync)
   );

   // all sequencer state, with rst_out driven straight from async-set flops
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state   <= ASSERT;
         r_cnt     <= '0;
         r_dom     <= '0;
         r_rst_out <= '1;
         r_done    <= 1'b0;
         r_ack     <= 1'b0;
         r_sw_flag <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_dom     <= w_dom;
         r_rst_out <= w_rst_out;
         r_done    <= w_done;
         r_ack     <= w_ack;
         r_sw_flag <= w_sw_flag;
      end

   // next-state: releases shift a zero in from bit 0 so domains clear strictly in index order
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_dom     = r_dom;
      w_rst_out = r_rst_out;
      w_done    = r_done;
      w_ack     = r_ack;
      w_sw_flag = r_sw_flag;
      case (r_state)
         ASSERT: begin
            if (!w_rst_sync) begin
               w_state = STRETCH;
               w_cnt   = '0;
            end
         end
         STRETCH: begin
            if (r_cnt == STRETCH_LAST) begin
               w_state   = RELEASE;
               w_cnt     = '0;
               w_dom     = DOM_W'(1);
               w_rst_out = r_rst_out << 1;
            end else w_cnt = r_cnt + 1'b1;
         end
         RELEASE: begin
            if (r_dom == DOM_END) begin
               w_state   = RUN;
               w_done    = 1'b1;
               w_ack     = r_sw_flag ? 1'b1 : r_ack;
               w_sw_flag = 1'b0;
            end else if (r_cnt == GAP_LAST) begin
               w_rst_out = r_rst_out << 1;
               w_dom     = r_dom + 1'b1;
               w_cnt     = '0;
            end else w_cnt = r_cnt + 1'b1;
         end
         RUN: begin
            if (sw_rst_req && !r_ack) begin
               w_state   = STRETCH;
               w_cnt     = '0;
               w_rst_out = '1;
               w_done    = 1'b0;
               w_sw_flag = 1'b1;
            end else if (r_ack && !sw_rst_req) w_ack = 1'b0;
         end
      endcase
   end

   assign rst_out    = r_rst_out;
   assign rst_done   = r_done;
   assign sw_rst_ack = r_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks plus a timeline model compared every cycle
module tb_reset_sequencer;

   localparam int S = 3;
   localparam int T = 16;
   localparam int N = 2;
   localparam int G = 4;
   localparam int D = T + (N - 1) * G + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req = 1'b0;
   logic         ack, done, ack2, done2;
   logic [N-1:0] rout;
   logic         rout2;
   int           n_chk = 0;
   int           n_err = 0;

   int           m_k = -(S + 1);
   logic         m_ack = 1'b0;
   logic         m_sw = 1'b0;
   logic [N-1:0] e_out;

   always #5 clk = ~clk;

   reset_sequencer #(.SYNC_STAGES(S), .STRETCH_CYCLES(T), .NUM_DOMAINS(N), .DOMAIN_GAP(G)) dut (
      .clk(clk), .rst(rst), .sw_rst_req(req), .sw_rst_ack(ack), .rst_out(rout), .rst_done(done)
   );

   reset_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(1), .NUM_DOMAINS(1), .DOMAIN_GAP(1)) dut2 (
      .clk(clk), .rst(rst), .sw_rst_req(req), .sw_rst_ack(ack2), .rst_out(rout2), .rst_done(done2)
   );

   // m_k counts edges since the stretch phase began; negative while waiting on the synchronizer
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         m_k   <= -(S + 1);
         m_ack <= 1'b0;
         m_sw  <= 1'b0;
      end else if (m_k >= D && req && !m_ack) begin
         m_k  <= 0;
         m_sw <= 1'b1;
      end else begin
         if (m_k >= D && m_ack && !req) m_ack <= 1'b0;
         if (m_k < D) m_k <= m_k + 1;
         if (m_k == D - 1 && m_sw) begin
            m_ack <= 1'b1;
            m_sw  <= 1'b0;
         end
      end

   always_comb begin
      e_out = '1;
      for (int d = 0; d < N; d++) e_out[d] = !(m_k >= T + d * G);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      chk("model_rst_out", 8'(rout), 8'(e_out));
      chk("model_done", 8'(done), 8'(m_k >= D));
      chk("model_ack", 8'(ack), 8'(m_ack));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #7;
      chk("reset_rst_out", 8'(rout), 8'h3);
      chk("reset_done", 8'(done), 8'h0);
      chk("reset_ack", 8'(ack), 8'h0);
      chk("reset_rst_out2", 8'(rout2), 8'h1);
      #15 rst = 1'b0;
      tick(3);
      chk("po_e3", 8'(rout), 8'h3);
      chk("sweep_e3", 8'(rout2), 8'h1);
      tick(1);
      chk("sweep_e4_out", 8'(rout2), 8'h0);
      chk("sweep_e4_done", 8'(done2), 8'h0);
      tick(1);
      chk("sweep_e5_done", 8'(done2), 8'h1);
      tick(14);
      chk("po_e19", 8'(rout), 8'h3);
      tick(1);
      chk("po_e20", 8'(rout), 8'h2);
      tick(3);
      chk("po_e23", 8'(rout), 8'h2);
      tick(1);
      chk("po_e24_out", 8'(rout), 8'h0);
      chk("po_e24_done", 8'(done), 8'h0);
      tick(1);
      chk("po_e25_done", 8'(done), 8'h1);
      chk("po_e25_ack", 8'(ack), 8'h0);

      rst = 1'b1;
      #1 chk("async_run_out", 8'(rout), 8'h3);
      chk("async_run_done", 8'(done), 8'h0);
      #2 rst = 1'b0;
      tick(10);
      #3 rst = 1'b1;
      #1 chk("async_stretch_out", 8'(rout), 8'h3);
      #1 rst = 1'b0;
      tick(24);
      chk("rerun_e24_out", 8'(rout), 8'h0);
      chk("rerun_e24_done", 8'(done), 8'h0);
      tick(1);
      chk("rerun_e25_done", 8'(done), 8'h1);

      req = 1'b1;
      tick(1);
      chk("sw_ek_out", 8'(rout), 8'h3);
      chk("sw_ek_done", 8'(done), 8'h0);
      tick(15);
      chk("sw_ek15", 8'(rout), 8'h3);
      tick(1);
      chk("sw_ek16", 8'(rout), 8'h2);
      tick(4);
      chk("sw_ek20", 8'(rout), 8'h0);
      chk("sw_ek20_ack", 8'(ack), 8'h0);
      tick(1);
      chk("sw_ek21_done", 8'(done), 8'h1);
      chk("sw_ek21_ack", 8'(ack), 8'h1);
      tick(5);
      chk("sw_hold_ack", 8'(ack), 8'h1);
      chk("sw_hold_out", 8'(rout), 8'h0);
      req = 1'b0;
      tick(1);
      chk("sw_ack_fall", 8'(ack), 8'h0);
      tick(2);
      chk("sw_after_done", 8'(done), 8'h1);

      rst = 1'b1;
      req = 1'b1;
      #2 rst = 1'b0;
      tick(25);
      chk("ign_e25_done", 8'(done), 8'h1);
      chk("ign_e25_ack", 8'(ack), 8'h0);
      tick(1);
      chk("ign_e26_out", 8'(rout), 8'h3);
      chk("ign_e26_done", 8'(done), 8'h0);
      tick(18);
      chk("swrel_out", 8'(rout), 8'h2);
      #3 rst = 1'b1;
      #1 chk("swrst_out", 8'(rout), 8'h3);
      chk("swrst_done", 8'(done), 8'h0);
      chk("swrst_ack", 8'(ack), 8'h0);
      req = 1'b0;
      #1 rst = 1'b0;
      tick(24);
      chk("swrst_e24_done", 8'(done), 8'h0);
      tick(1);
      chk("swrst_e25_done", 8'(done), 8'h1);
      chk("swrst_e25_ack", 8'(ack), 8'h0);
      tick(3);
      chk("swrst_no_ack", 8'(ack), 8'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
